// File: rtl/packet_rx_monitor.sv
//------------------------------------------------------------------------------
// packet_rx_monitor : receive-side packet framing checker with header capture
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package packet_pkg;
    localparam int byte_width_bits        = 8;
    localparam int packet_width_bits      = 64;
    localparam int byte_enable_width_bits = packet_width_bits / byte_width_bits;
endpackage

module packet_rx_monitor
    import packet_pkg::*;
#(
    parameter int HEADER_BYTES = 14,
    parameter int LEN_WIDTH    = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [packet_width_bits-1:0]  in_data,
    input  logic [byte_enable_width_bits-1:0] in_byte_enable,
    input  logic                          in_sop,
    input  logic                          in_eop,
    output logic                          hdr_valid,
    output logic [8*HEADER_BYTES-1:0]     hdr_data,
    output logic                          pkt_done,
    output logic [LEN_WIDTH-1:0]          pkt_len,
    output logic                          pkt_short,
    output logic                          pkt_err,
    output logic                          err_no_sop,
    output logic                          err_no_eop,
    output logic                          err_byte_enable,
    output logic [CNT_WIDTH-1:0]          pkt_count
);
    localparam int W  = packet_width_bits;
    localparam int E  = byte_enable_width_bits;
    localparam int HW = 8 * HEADER_BYTES;
    localparam int OW = LEN_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] HB_L = LEN_WIDTH'(HEADER_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   offset_q, offset_d;
    logic                   err_q, err_d;
    logic [HW-1:0]          hdr_q, hdr_d;
    logic                   hdr_valid_q, hdr_valid_d;
    logic                   pkt_done_q, pkt_done_d;
    logic [LEN_WIDTH-1:0]   pkt_len_q, pkt_len_d;
    logic                   pkt_short_q, pkt_short_d;
    logic                   pkt_err_q, pkt_err_d;
    logic                   no_sop_q, no_sop_d;
    logic                   no_eop_q, no_eop_d;
    logic                   be_err_q, be_err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                   do_proc;
    logic [LEN_WIDTH-1:0]   base_off;
    logic                   base_err;
    logic [OW-1:0]          lanes;
    logic [OW-1:0]          sum;
    logic [LEN_WIDTH-1:0]   new_off;
    logic                   new_err;
    logic                   be_legal;
    logic [E-1:0]           be_inv;
    logic [E-1:0]           be_inv_inc;

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        err_d       = err_q;
        hdr_d       = hdr_q;
        hdr_valid_d = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_len_d   = pkt_len_q;
        pkt_short_d = pkt_short_q;
        pkt_err_d   = pkt_err_q;
        no_sop_d    = 1'b0;
        no_eop_d    = 1'b0;
        be_err_d    = 1'b0;
        cnt_d       = cnt_q;
        do_proc     = 1'b0;
        base_off    = offset_q;
        base_err    = err_q;
        lanes       = '0;
        sum         = '0;
        new_off     = '0;
        new_err     = 1'b0;

        // An eop mask is legal when its complement is a (possibly empty) run of LSB ones
        be_inv     = ~in_byte_enable;
        be_inv_inc = be_inv + E'(1);
        be_legal   = in_eop ? (in_byte_enable[E-1] && ((be_inv & be_inv_inc) == '0))
                            : (&in_byte_enable);

        if (in_valid) begin
            if (in_sop) begin
                no_eop_d = (state_q == S_OPEN);
                base_off = '0;
                base_err = 1'b0;
                hdr_d    = '0;
                do_proc  = 1'b1;
            end else if (state_q == S_OPEN) begin
                do_proc  = 1'b1;
            end else if (state_q == S_IDLE) begin
                no_sop_d = 1'b1;
                state_d  = S_DROP;
            end
        end

        if (do_proc) begin
            for (int i = 0; i < E; i++) begin
                lanes = lanes + OW'(in_byte_enable[E-1-i]);
                for (int h = 0; h < HEADER_BYTES; h++) begin
                    if (in_byte_enable[E-1-i] && (({1'b0, base_off} + OW'(i)) == OW'(h))) begin
                        hdr_d[HW-1-8*h -: 8] = in_data[W-1-8*i -: 8];
                    end
                end
            end
            sum         = {1'b0, base_off} + lanes;
            new_off     = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
            new_err     = base_err | ~be_legal;
            be_err_d    = ~be_legal;
            hdr_valid_d = (base_off < HB_L) && (new_off >= HB_L);
            offset_d    = new_off;
            err_d       = new_err;
            if (in_eop) begin
                pkt_done_d  = 1'b1;
                pkt_len_d   = new_off;
                pkt_short_d = (new_off < HB_L);
                pkt_err_d   = new_err;
                if (!new_err) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                state_d = S_IDLE;
            end else begin
                state_d = S_OPEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            offset_q    <= '0;
            err_q       <= 1'b0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_len_q   <= '0;
            pkt_short_q <= 1'b0;
            pkt_err_q   <= 1'b0;
            no_sop_q    <= 1'b0;
            no_eop_q    <= 1'b0;
            be_err_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            err_q       <= err_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            pkt_done_q  <= pkt_done_d;
            pkt_len_q   <= pkt_len_d;
            pkt_short_q <= pkt_short_d;
            pkt_err_q   <= pkt_err_d;
            no_sop_q    <= no_sop_d;
            no_eop_q    <= no_eop_d;
            be_err_q    <= be_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hdr_valid       = hdr_valid_q;
    assign hdr_data        = hdr_q;
    assign pkt_done        = pkt_done_q;
    assign pkt_len         = pkt_len_q;
    assign pkt_short       = pkt_short_q;
    assign pkt_err         = pkt_err_q;
    assign err_no_sop      = no_sop_q;
    assign err_no_eop      = no_eop_q;
    assign err_byte_enable = be_err_q;
    assign pkt_count       = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_packet_rx_monitor.sv
//------------------------------------------------------------------------------
// tb_packet_rx_monitor : directed table plus randomized traffic vs. byte model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_packet_rx_monitor;
    import packet_pkg::*;

    localparam int HB = 14;
    localparam int LW = 16;
    localparam int CW = 32;
    localparam int W  = packet_width_bits;
    localparam int E  = byte_enable_width_bits;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [W-1:0]    in_data = '0;
    logic [E-1:0]    in_byte_enable = '0;
    logic            in_sop = 1'b0;
    logic            in_eop = 1'b0;
    logic            hdr_valid;
    logic [8*HB-1:0] hdr_data;
    logic            pkt_done;
    logic [LW-1:0]   pkt_len;
    logic            pkt_short;
    logic            pkt_err;
    logic            err_no_sop;
    logic            err_no_eop;
    logic            err_byte_enable;
    logic [CW-1:0]   pkt_count;

    packet_rx_monitor #(.HEADER_BYTES(HB), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_byte_enable(in_byte_enable), .in_sop(in_sop), .in_eop(in_eop),
        .hdr_valid(hdr_valid), .hdr_data(hdr_data), .pkt_done(pkt_done),
        .pkt_len(pkt_len), .pkt_short(pkt_short), .pkt_err(pkt_err),
        .err_no_sop(err_no_sop), .err_no_eop(err_no_eop),
        .err_byte_enable(err_byte_enable), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: the packet as an array of header bytes and a running byte count
    bit          m_open, m_drop, m_err;
    int          m_off;
    logic [7:0]  m_hdr [HB];
    bit          e_hv, e_done, e_short, e_err, e_nsop, e_neop, e_ebe;
    int          e_len;
    int unsigned e_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit legal_be(input logic [E-1:0] be, input bit eop);
        int lead = 0;
        int ones = 0;
        bit run = 1'b1;
        if (!eop) return (be == {E{1'b1}});
        for (int j = E - 1; j >= 0; j--) begin
            if (be[j]) ones++;
            if (run && be[j]) lead++;
            else run = 1'b0;
        end
        return (lead >= 1) && (lead == ones);
    endfunction

    task automatic model_reset();
        m_open = 0; m_drop = 0; m_err = 0; m_off = 0;
        for (int h = 0; h < HB; h++) m_hdr[h] = 8'h00;
        e_hv = 0; e_done = 0; e_short = 0; e_err = 0;
        e_nsop = 0; e_neop = 0; e_ebe = 0; e_len = 0; e_cnt = 0;
    endtask

    task automatic model_word(input bit e, input logic [E-1:0] be, input logic [W-1:0] d);
        int old = m_off;
        int n = 0;
        for (int i = 0; i < E; i++) begin
            if (be[E-1-i]) begin
                if (m_off + i < HB) m_hdr[m_off + i] = d[W-1-8*i -: 8];
                n++;
            end
        end
        m_off = (m_off + n > 65535) ? 65535 : m_off + n;
        if (!legal_be(be, e)) begin
            e_ebe = 1;
            m_err = 1;
        end
        e_hv = (old < HB) && (m_off >= HB);
        if (e) begin
            e_done = 1; e_len = m_off; e_short = (m_off < HB); e_err = m_err;
            if (!m_err) e_cnt++;
            m_open = 0;
        end else begin
            m_open = 1;
        end
    endtask

    task automatic model_step(input bit v, input bit s, input bit e,
                              input logic [E-1:0] be, input logic [W-1:0] d);
        e_hv = 0; e_done = 0; e_nsop = 0; e_neop = 0; e_ebe = 0;
        if (v) begin
            if (s) begin
                if (m_open) e_neop = 1;
                m_off = 0; m_err = 0; m_drop = 0;
                for (int h = 0; h < HB; h++) m_hdr[h] = 8'h00;
                model_word(e, be, d);
            end else if (m_open) begin
                model_word(e, be, d);
            end else if (!m_drop) begin
                e_nsop = 1;
                m_drop = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [8*HB-1:0] exp_hdr;
        for (int h = 0; h < HB; h++) exp_hdr[8*HB-1-8*h -: 8] = m_hdr[h];
        chk({tag, ".hdr_valid"},  128'(hdr_valid),       128'(e_hv));
        chk({tag, ".hdr_data"},   128'(hdr_data),        128'(exp_hdr));
        chk({tag, ".pkt_done"},   128'(pkt_done),        128'(e_done));
        chk({tag, ".pkt_len"},    128'(pkt_len),         128'(e_len));
        chk({tag, ".pkt_short"},  128'(pkt_short),       128'(e_short));
        chk({tag, ".pkt_err"},    128'(pkt_err),         128'(e_err));
        chk({tag, ".err_no_sop"}, 128'(err_no_sop),      128'(e_nsop));
        chk({tag, ".err_no_eop"}, 128'(err_no_eop),      128'(e_neop));
        chk({tag, ".err_be"},     128'(err_byte_enable), 128'(e_ebe));
        chk({tag, ".pkt_count"},  128'(pkt_count),       128'(e_cnt));
    endtask

    task automatic step(input string tag, input bit v, input bit s, input bit e,
                        input logic [E-1:0] be, input logic [W-1:0] d);
        in_valid = v; in_sop = s; in_eop = e; in_byte_enable = be; in_data = d;
        @(posedge clk);
        model_step(v, s, e, be, d);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; in_sop = 0; in_eop = 0;
        rst_n = 0;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        bit         v, s, e;
        logic [7:0] be;
        bit         hv, done, nsop, neop, ebe;
        int         len;
        bit         sh, er;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit v, s, e, input logic [7:0] be,
                                input bit hv, done, nsop, neop, ebe,
                                input int len, input bit sh, er, input int cnt);
        vec_t r;
        r.v = v; r.s = s; r.e = e; r.be = be; r.hv = hv; r.done = done;
        r.nsop = nsop; r.neop = neop; r.ebe = ebe; r.len = len; r.sh = sh; r.er = er; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] d;
        logic [7:0]   full;
        bit           v, s, e;
        logic [7:0]   be;

        //            v s e  be      hv dn ns ne eb len sh er cnt
        tbl.push_back(mk(1,1,0,8'hFF, 0,0,0,0,0,  0, 0,0, 0));  // 20-byte packet
        tbl.push_back(mk(1,0,0,8'hFF, 1,0,0,0,0,  0, 0,0, 0));
        tbl.push_back(mk(1,0,1,8'hF0, 0,1,0,0,0, 20, 0,0, 1));
        tbl.push_back(mk(1,1,1,8'hF8, 0,1,0,0,0,  5, 1,0, 2));  // 5-byte single word
        tbl.push_back(mk(1,1,0,8'hFF, 0,0,0,0,0,  0, 0,0, 2));  // 16 bytes, then 8 back-to-back
        tbl.push_back(mk(1,0,1,8'hFF, 1,1,0,0,0, 16, 0,0, 3));
        tbl.push_back(mk(1,1,1,8'hFF, 0,1,0,0,0,  8, 1,0, 4));
        tbl.push_back(mk(1,1,0,8'hFF, 0,0,0,0,0,  0, 0,0, 4));  // sop interrupts open packet
        tbl.push_back(mk(1,1,0,8'hFF, 0,0,0,1,0,  0, 0,0, 4));
        tbl.push_back(mk(1,0,1,8'hF0, 0,1,0,0,0, 12, 1,0, 5));
        tbl.push_back(mk(1,0,0,8'hFF, 0,0,1,0,0,  0, 0,0, 5));  // words without sop
        tbl.push_back(mk(1,0,1,8'hFF, 0,0,0,0,0,  0, 0,0, 5));
        tbl.push_back(mk(0,0,0,8'h00, 0,0,0,0,0,  0, 0,0, 5));
        tbl.push_back(mk(1,1,0,8'hFF, 0,0,0,0,0,  0, 0,0, 5));
        tbl.push_back(mk(1,0,1,8'h80, 0,1,0,0,0,  9, 1,0, 6));
        tbl.push_back(mk(1,1,1,8'h0F, 0,1,0,0,1,  4, 1,1, 6));  // illegal eop mask

        model_reset();
        #12;
        compare_all("por");
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[k]) begin
            d = {$urandom, $urandom};
            step("tbl_model", tbl[k].v, tbl[k].s, tbl[k].e, tbl[k].be, d);
            chk("tbl.hdr_valid", 128'(hdr_valid), 128'(tbl[k].hv));
            chk("tbl.pkt_done", 128'(pkt_done), 128'(tbl[k].done));
            chk("tbl.err_no_sop", 128'(err_no_sop), 128'(tbl[k].nsop));
            chk("tbl.err_no_eop", 128'(err_no_eop), 128'(tbl[k].neop));
            chk("tbl.err_be", 128'(err_byte_enable), 128'(tbl[k].ebe));
            chk("tbl.pkt_count", 128'(pkt_count), 128'(tbl[k].cnt));
            if (tbl[k].done) begin
                chk("tbl.pkt_len", 128'(pkt_len), 128'(tbl[k].len));
                chk("tbl.pkt_short", 128'(pkt_short), 128'(tbl[k].sh));
                chk("tbl.pkt_err", 128'(pkt_err), 128'(tbl[k].er));
            end
        end

        // Single-word short packet: header holds 5 bytes followed by zeros
        step("short_hdr", 1, 1, 1, 8'hF8, 64'h1122334455667788);
        chk("short_hdr.value", 128'(hdr_data), 128'({40'h1122334455, 72'h0}));

        // Reset in the middle of a packet abandons it silently
        step("mid_pkt", 1, 1, 0, 8'hFF, {$urandom, $urandom});
        do_reset();
        chk("post_reset.pkt_count", 128'(pkt_count), 128'(0));
        step("after_reset", 1, 1, 1, 8'hFF, {$urandom, $urandom});
        chk("after_reset.pkt_count", 128'(pkt_count), 128'(1));

        full = 8'hFF;
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 5) == 0);
            e = ($urandom_range(0, 3) == 0);
            if (e) be = full << (8 - $urandom_range(1, 8));
            else   be = full;
            if ($urandom_range(0, 11) == 0) be = 8'($urandom);
            step("rand", v, s, e, be, {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
